// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: opcodes, forwarding selects, hazard FSM states
// and operand-usage decode helpers.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// EX-stage operand forwarding select for one source register.
// The younger EX/MEM result takes precedence over MEM/WB.
module fwd_select
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit_param.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: load-use stalls of
// configurable length, dmem freeze, branch flush, EX forwarding and a stall counter.
//
// state | meaning
// RUN   | normal flow; load-use detected here costs one bubble immediately
// STALL | extra load-use bubbles remaining (stall_cnt), load-use not re-checked
module hazard_unit_param
  import riscv_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FWD_STORE_DATA  = 1,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [6:0]        ex_opcode,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int CW = $clog2(LOAD_USE_STALLS + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_USE_STALLS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 7) begin : g_bad_stalls
    $fatal(1, "hazard_unit_param: LOAD_USE_STALLS must be within 1..7");
  end

  hz_state_e     state, state_nxt;
  logic [CW-1:0] stall_cnt, stall_cnt_nxt;
  logic          load_use;
  fwd_sel_e      sel_a, sel_b;

  // A store whose data (rs2) comes from the load is covered by the MEM->MEM forward,
  // unless the load also feeds the store's address (rs1).
  always_comb begin
    load_use = 1'b0;
    if (ex_opcode == OP_LOAD && ex_rd != '0) begin
      if (uses_rs1(id_opcode) && ex_rd == id_rs1) begin
        load_use = 1'b1;
      end else if (uses_rs2(id_opcode) && ex_rd == id_rs2 &&
                   !((FWD_STORE_DATA != 0) && id_opcode == OP_STORE && ex_rd != id_rs1)) begin
        load_use = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    if (dmem_busy) begin
      state_nxt     = state;
    end else if (ex_branch_taken) begin
      state_nxt     = RUN;
    end else if (state == STALL) begin
      stall_cnt_nxt = stall_cnt - CNT_ONE;
      if (stall_cnt == CNT_ONE) state_nxt = RUN;
    end else if (load_use && LOAD_USE_STALLS > 1) begin
      state_nxt     = STALL;
      stall_cnt_nxt = CNT_INIT;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (dmem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
    end else if (ex_branch_taken) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (state == STALL || load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b)
  );

  assign fwd_a = rst ? 2'b00 : sel_a;
  assign fwd_b = rst ? 2'b00 : sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_write) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed bench for hazard_unit_param: one instance with single-cycle load-use
// stalls and one with three, driven by the same pipeline-state vectors.
module tb_hazard_unit_param;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] id_opcode, ex_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       mem_reg_write, wb_reg_write, ex_branch_taken, dmem_busy;

  logic        pc1, ifid1, bub1, fl1;
  logic [1:0]  fa1, fb1;
  logic [31:0] sc1;
  logic        pc3, ifid3, bub3, fl3;
  logic [1:0]  fa3, fb3;
  logic [31:0] sc3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit_param #(.REG_AW(5), .LOAD_USE_STALLS(1), .FWD_STORE_DATA(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc1), .if_id_write(ifid1), .id_ex_bubble(bub1), .if_id_flush(fl1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1)
  );

  hazard_unit_param #(.REG_AW(5), .LOAD_USE_STALLS(3), .FWD_STORE_DATA(1), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc3), .if_id_write(ifid3), .id_ex_bubble(bub3), .if_id_flush(fl3),
    .fwd_a(fa3), .fwd_b(fb3), .stall_cycles(sc3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns 1 time unit after the rising edge, away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_opcode = OP_RTYPE; id_rs1 = 5'd1; id_rs2 = 5'd2;
    ex_opcode = OP_RTYPE; ex_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    ex_branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic load_hazard();
    ex_opcode = OP_LOAD; ex_rd = 5'd5;
    id_opcode = OP_RTYPE; id_rs1 = 5'd5; id_rs2 = 5'd2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    mem_rd = 5'd9; ex_rs1 = 5'd9; mem_reg_write = 1'b1;
    tick(); tick();
    // reset outputs, forwarding gated
    chk("rst_pc",    pc1,   1'b0);
    chk("rst_ifid",  ifid1, 1'b0);
    chk("rst_bub",   bub1,  1'b1);
    chk("rst_flush", fl1,   1'b1);
    chk("rst_fwd_a", fa1,   2'b00);
    chk("rst_cnt",   sc1,   32'd0);

    rst = 1'b0;
    idle();
    tick();
    chk("run_pc",    pc1, 1'b1);
    chk("run_bub",   bub1, 1'b0);
    chk("run_flush", fl3, 1'b0);
    chk("run_cnt3",  sc3, 32'd0);

    // T1/T2 load-use, 1 vs 3 bubbles
    load_hazard(); settle();
    chk("t1_pc1",  pc1,  1'b0);
    chk("t1_bub1", bub1, 1'b1);
    chk("t1_pc3",  pc3,  1'b0);
    tick();
    idle(); settle();
    chk("t1_pc1_after", pc1, 1'b1);
    chk("t2_pc3_s1",  pc3,  1'b0);
    chk("t2_bub3_s1", bub3, 1'b1);
    tick();
    chk("t2_pc3_s2", pc3, 1'b0);
    tick();
    chk("t2_pc3_run", pc3, 1'b1);
    chk("t1_cnt1", sc1, 32'd1);
    chk("t2_cnt3", sc3, 32'd3);

    // T3 store data forwarding
    ex_opcode = OP_LOAD; ex_rd = 5'd7;
    id_opcode = OP_STORE; id_rs1 = 5'd2; id_rs2 = 5'd7; settle();
    chk("t3_sw_data_pc", pc1, 1'b1);
    id_rs1 = 5'd7; settle();
    chk("t3_sw_addr_pc", pc1, 1'b0);
    id_opcode = OP_BRANCH; id_rs1 = 5'd2; id_rs2 = 5'd7; settle();
    chk("t3_br_rs2_pc", pc1, 1'b0);

    // T4 x0 and unused operands
    ex_rd = 5'd0; id_opcode = OP_RTYPE; id_rs1 = 5'd0; id_rs2 = 5'd3; settle();
    chk("t4_x0_pc", pc1, 1'b1);
    ex_rd = 5'd6; id_opcode = OP_LUI; id_rs1 = 5'd6; settle();
    chk("t4_lui_pc", pc1, 1'b1);
    id_opcode = OP_IMM; id_rs1 = 5'd1; id_rs2 = 5'd6; settle();
    chk("t4_imm_rs2_pc", pc1, 1'b1);
    idle(); settle();

    // T5 dmem freeze during STALL
    load_hazard(); settle();
    tick();
    idle(); dmem_busy = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      chk("t5_busy_pc",   pc3,   1'b0);
      chk("t5_busy_ifid", ifid3, 1'b0);
      chk("t5_busy_bub",  bub3,  1'b0);
      chk("t5_busy_fl",   fl3,   1'b0);
      tick();
    end
    dmem_busy = 1'b0; settle();
    chk("t5_resume1_pc",  pc3,  1'b0);
    chk("t5_resume1_bub", bub3, 1'b1);
    tick();
    chk("t5_resume2_bub", bub3, 1'b1);
    tick();
    chk("t5_run_pc", pc3, 1'b1);
    chk("t5_cnt3", sc3, 32'd10);
    chk("t5_cnt1", sc1, 32'd6);

    // T5 branch aborts STALL
    load_hazard(); settle();
    tick();
    idle(); ex_branch_taken = 1'b1; settle();
    chk("t5_br_pc",   pc3,   1'b1);
    chk("t5_br_fl",   fl3,   1'b1);
    chk("t5_br_bub",  bub3,  1'b1);
    chk("t5_br_ifid", ifid3, 1'b1);
    dmem_busy = 1'b1; settle();
    chk("t5_busy_over_br_pc", pc3, 1'b0);
    chk("t5_busy_over_br_fl", fl3, 1'b0);
    dmem_busy = 1'b0; settle();
    tick();
    ex_branch_taken = 1'b0; settle();
    chk("t5_br_run_pc",  pc3,  1'b1);
    chk("t5_br_run_bub", bub3, 1'b0);

    // T6 forwarding
    mem_rd = 5'd9; wb_rd = 5'd9; ex_rs1 = 5'd9; mem_reg_write = 1'b1; wb_reg_write = 1'b1; settle();
    chk("t6_fa_mem", fa1, 2'b10);
    mem_reg_write = 1'b0; settle();
    chk("t6_fa_wb", fa1, 2'b01);
    wb_reg_write = 1'b0; settle();
    chk("t6_fa_rf", fa1, 2'b00);
    ex_rs2 = 5'd9; mem_reg_write = 1'b1; settle();
    chk("t6_fb_mem", fb3, 2'b10);
    mem_rd = 5'd0; ex_rs2 = 5'd0; wb_rd = 5'd4; settle();
    chk("t6_fb_x0", fb3, 2'b00);
    ex_rs1 = 5'd4; wb_reg_write = 1'b1; settle();
    chk("t6_fa_wb_only", fa3, 2'b01);
    idle(); settle();

    // T6 reset during STALL
    load_hazard(); settle();
    tick();
    idle(); rst = 1'b1; settle();
    chk("t6_rst_pc", pc3, 1'b0);
    chk("t6_rst_fl", fl3, 1'b1);
    tick();
    rst = 1'b0; settle();
    chk("t6_rst_run_pc", pc3, 1'b1);
    chk("t6_rst_cnt", sc3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
